adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one structural_adder between NUM_REQ requesters via per-requester valid/ready ports.
//  Grants are round-robin. Accepted operands pass through a 2-stage pipeline (operand reg -> adder -> result reg).
//  Results return on a single tagged response port with valid/ready backpressure.
//  Sits between lab compute clients and the shared adder datapath.
// PARAMETERS
//  N        32  operand width; sum is N+1 bits
//  NUM_REQ  4   number of requesters (>=2)
//  ID_W     $clog2(NUM_REQ)  localparam, requester tag width
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   NUM_REQ      requester i has an operand pair
//  req_ready  out  NUM_REQ      one-hot; requester i accepted this cycle when valid&ready
//  req_a      in   NUM_REQ*N    packed operand a; slice i = [i*N +: N]
//  req_b      in   NUM_REQ*N    packed operand b, same packing
//  resp_valid out  1            resp_sum/resp_id hold a result
//  resp_ready in   1            consumer takes result when valid&ready
//  resp_sum   out  N+1          a+b, unsigned, carry in MSB (never overflows)
//  resp_id    out  ID_W         index of requester that issued the op
// BEHAVIOUR
//  Reset: resp_valid=0, resp_sum=0, resp_id=0, s1_valid=0, rr pointer=0; req_ready=0 while rst high.
//  Reset mid-operation: all in-flight ops (s1, s2) are discarded without a response.
//  Pipeline: s1 = {s1_valid,s1_a,s1_b,s1_id}; s2 = {resp_valid,resp_sum,resp_id}.
//  s2_adv = !resp_valid | resp_ready. s1_adv = s1_valid & s2_adv. can_acc = !s1_valid | s2_adv.
//  On s2_adv, s2 loads {s1_valid, adder.sum, s1_id}. An s2 load with s1_valid=0 clears resp_valid.
//  Latency: accept in cycle T -> resp_valid in T+2 (no backpressure). Throughput is 1 op/cycle.
//  Backpressure: while resp_valid & !resp_ready, s2 holds stable, s1 holds, and req_ready=0 if s1 is full.
//  Arbitration: combinational one-hot grant, the first req_valid at or after ptr, searching upward with wrap.
//   req_ready = grant & {NUM_REQ{can_acc & !rst}}.
//  Pointer update: only on an accepted handshake, ptr <= granted+1 mod NUM_REQ. Idle or stalled cycles leave ptr unchanged.
//  Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,... No requester waits > NUM_REQ accepts.
//  Protocol: a requester holds req_valid and its operands stable until accepted. The arbiter never drops a grant target mid-stall.
//  Adder: structural_adder #(N) operates on s1_a/s1_b. Its output is sampled only into s2.
//  Response ordering equals acceptance order. No reordering.
//  Simultaneous events: s2 unload, s1->s2 move and a new accept all occur in one cycle.
// STRUCTURE
//  Shared header adder_arbiter_defs.vh: default N/NUM_REQ and the packing macro for [i*N +: N].
//  Sub-module rr_arbiter #(NUM_REQ): inputs req, advance; output one-hot grant; owns ptr.
//  Top: instantiates rr_arbiter and structural_adder, holds s1/s2 regs and the operand mux.
// TESTING (N=32, NUM_REQ=4)
//  1. Reset then single op: req0 a=1000 b=1000 at T.
//     -> req_ready[0]=1 at T; resp_valid=1, resp_sum=2000, resp_id=0 at T+2.
//  2. All 4 valid continuously, resp_ready=1, a=b=i*1000.
//     -> accept order 0,1,2,3,0; back-to-back resp_sum 0,2000,4000,6000; one per cycle.
//  3. Overflow: a=32'hFFFF_FFFF, b=1 -> resp_sum=33'h1_0000_0000.
//  4. Backpressure: resp_ready=0 for 5 cycles with req1,req2 valid.
//     -> one result held stable, one op in s1, req_ready=0, ptr frozen.
//     -> on release, the results drain in order with no loss or duplication.
//  5. Reset mid-operation: assert rst with s1 and s2 full.
//     -> next cycle resp_valid=0, ptr=0; no stale response after deassert.
//  6. Sparse: only req3 valid after req3 was last served.
//     -> granted immediately (wrap search), resp_id=3.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and small index helpers for the adder_arbiter slice.
package adder_arbiter_pkg;

    localparam int DEFAULT_N       = 32;
    localparam int DEFAULT_NUM_REQ = 4;

    // Increment with wrap, valid for requester counts that are not powers of two.
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the priority pointer moves only on an accepted grant.
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              idx;

    // Search upward from ptr with wrap; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/structural_adder.sv
// Ripple-carry adder built bit by bit; carry-out lands in the MSB of sum.
module structural_adder
    import adder_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    logic carry;

    // Full-adder chain; the carry variable threads through the loop rather than a vector.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        sum[N] = carry;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one structural_adder among NUM_REQ requesters through a 2-stage
// operand/result pipeline with round-robin grants and a tagged response port.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int N       = DEFAULT_N,
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [N:0]           resp_sum,
    output logic [ID_W-1:0]      resp_id
);

    logic               s1_valid;
    logic [N-1:0]       s1_a;
    logic [N-1:0]       s1_b;
    logic [ID_W-1:0]    s1_id;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [N-1:0]       mux_a;
    logic [N-1:0]       mux_b;
    logic [N:0]         adder_sum;
    logic               s2_adv;
    logic               s1_adv;
    logic               can_acc;
    logic               accept;

    assign s2_adv    = !resp_valid || resp_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign can_acc   = !s1_valid || s2_adv;
    assign req_ready = grant & {NUM_REQ{can_acc && !rst}};
    assign accept    = |(req_valid & req_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is one-hot, so an AND-OR mux picks the winning operand pair.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mux_a = mux_a | req_a[slice_lo(i, N) +: N];
                mux_b = mux_b | req_b[slice_lo(i, N) +: N];
            end
        end
    end

    structural_adder #(
        .N (N)
    ) u_structural_adder (
        .a   (s1_a),
        .b   (s1_b),
        .sum (adder_sum)
    );

    // A new accept refills s1 even as its old contents move on to s2 in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= mux_a;
            s1_b     <= mux_b;
            s1_id    <= grant_idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
        end else if (s2_adv) begin
            resp_valid <= s1_valid;
            resp_sum   <= adder_sum;
            resp_id    <= s1_id;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scenario bench for adder_arbiter: a negedge monitor scoreboards every response
// against the operands accepted, while each test task checks timing and grants.
module tb_adder_arbiter;

    localparam int N       = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [N:0]      sum;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [N:0]           resp_sum;
    logic [ID_W-1:0]      resp_id;

    exp_t               sb[$];
    exp_t               mon_exp;
    logic [NUM_REQ-1:0] acc_mask = '0;
    int                 compared   = 0;
    int                 mismatched = 0;

    always #5 clk = ~clk;

    adder_arbiter #(
        .N       (N),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
    );

    // Scoreboard: pop on every response handshake, push on every accepted request.
    always @(negedge clk) begin
        acc_mask = req_valid & req_ready;
        if (!rst && resp_valid && resp_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL sb_unexpected: got id=%0d sum=%0h, required no response", resp_id, resp_sum);
            end else begin
                mon_exp = sb.pop_front();
                if (resp_sum !== mon_exp.sum || resp_id !== mon_exp.id) begin
                    mismatched++;
                    $display("[TB] FAIL sb_resp: got id=%0d sum=%0h, required id=%0d sum=%0h",
                             resp_id, resp_sum, mon_exp.id, mon_exp.sum);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_mask[i]) begin
                sb.push_back({ID_W'(i), {1'b0, req_a[i*N +: N]} + {1'b0, req_b[i*N +: N]}});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; requesters drop valid once their op was accepted.
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (sb.size() == 0 && !resp_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d ops outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(i + 1), 32'(i + 2));
        req_valid = '1;
        step();
        step();
        compared++;
        if (req_ready !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: got %b, required 0000", req_ready);
        end
        compared++;
        if (resp_valid !== 1'b0 || resp_sum !== '0 || resp_id !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_resp: got v=%b sum=%0h id=%0d, required v=0 sum=0 id=0",
                     resp_valid, resp_sum, resp_id);
        end
        req_valid = '0;
        rst       = 1'b0;
        sb.delete();
    endtask

    task automatic test_single_op();
        set_op(0, 32'd1000, 32'd1000);
        req_valid = 4'b0001;
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL single_ready: got %b, required 0001", req_ready);
        end
        step();
        compared++;
        if (resp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_early: got resp_valid=%b at T+1, required 0", resp_valid);
        end
        step();
        compared++;
        if (resp_valid !== 1'b1 || resp_sum !== 33'd2000 || resp_id !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL single_resp: got v=%b sum=%0d id=%0d, required v=1 sum=2000 id=0",
                     resp_valid, resp_sum, resp_id);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [N:0]         exp_sum;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(i * 1000), 32'(i * 1000));
        req_valid = '1;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k < 5) begin
                exp_rdy = 4'b0001 << (k % 4);
                compared++;
                if (req_ready !== exp_rdy) begin
                    mismatched++;
                    $display("[TB] FAIL rr_grant%0d: got %b, required %b", k, req_ready, exp_rdy);
                end
            end
            if (k >= 2) begin
                exp_sum = 33'(((k - 2) % 4) * 2000);
                compared++;
                if (resp_valid !== 1'b1 || resp_sum !== exp_sum) begin
                    mismatched++;
                    $display("[TB] FAIL rr_stream%0d: got v=%b sum=%0d, required v=1 sum=%0d",
                             k, resp_valid, resp_sum, exp_sum);
                end
            end
            step();
            req_valid = (k < 4) ? '1 : '0;
        end
        compared++;
        if (resp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rr_tail: got resp_valid=%b, required 0", resp_valid);
        end
    endtask

    task automatic test_overflow();
        set_op(1, 32'hFFFF_FFFF, 32'd1);
        req_valid = 4'b0010;
        step();
        step();
        compared++;
        if (resp_valid !== 1'b1 || resp_sum !== 33'h1_0000_0000 || resp_id !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL overflow: got v=%b sum=%0h id=%0d, required v=1 sum=100000000 id=1",
                     resp_valid, resp_sum, resp_id);
        end
        drain();
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        set_op(1, 32'd11, 32'd22);
        set_op(2, 32'd33, 32'd44);
        req_valid = 4'b0110;
        #1;
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL bp_first: got %b, required 0100", req_ready);
        end
        step();
        #1;
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL bp_second: got %b, required 0010", req_ready);
        end
        step();
        set_op(0, 32'd5, 32'd6);
        set_op(3, 32'd7, 32'd8);
        req_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            #1;
            compared++;
            if (req_ready !== '0 || resp_valid !== 1'b1 || resp_sum !== 33'd77 || resp_id !== 2'd2) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b sum=%0d id=%0d, required rdy=0000 v=1 sum=77 id=2",
                         c, req_ready, resp_valid, resp_sum, resp_id);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL bp_release: got %b, required 1000", req_ready);
        end
        step();
        #1;
        compared++;
        if (req_ready !== 4'b0001 || resp_sum !== 33'd33 || resp_id !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL bp_next: got rdy=%b sum=%0d id=%0d, required rdy=0001 sum=33 id=1",
                     req_ready, resp_sum, resp_id);
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        set_op(1, 32'd100, 32'd200);
        req_valid = 4'b0010;
        step();
        set_op(2, 32'd300, 32'd400);
        req_valid = 4'b0100;
        step();
        compared++;
        if (resp_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_fill: got resp_valid=%b, required 1", resp_valid);
        end
        rst       = 1'b1;
        req_valid = 4'b1010;
        step();
        sb.delete();
        #1;
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== '0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got v=%b rdy=%b, required v=0 rdy=0000", resp_valid, req_ready);
        end
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (resp_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_stale%0d: got resp_valid=%b, required 0", c, resp_valid);
            end
            step();
        end
        set_op(1, 32'd1, 32'd2);
        set_op(3, 32'd3, 32'd4);
        req_valid = 4'b1010;
        #1;
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL mid_ptr: got %b, required 0010", req_ready);
        end
        step();
        #1;
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL mid_next: got %b, required 1000", req_ready);
        end
        step();
        drain();
    endtask

    task automatic test_sparse();
        set_op(3, 32'd123, 32'd456);
        req_valid = 4'b1000;
        #1;
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL sparse_grant: got %b, required 1000", req_ready);
        end
        step();
        step();
        compared++;
        if (resp_valid !== 1'b1 || resp_sum !== 33'd579 || resp_id !== 2'd3) begin
            mismatched++;
            $display("[TB] FAIL sparse_resp: got v=%b sum=%0d id=%0d, required v=1 sum=579 id=3",
                     resp_valid, resp_sum, resp_id);
        end
        drain();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_sparse();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sb_leftover: got %0d ops outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
